// File: rtl/asap1_pkg.sv
// Shared constants for the 8-bit bus CPU control path: opcodes, step numbers,
// control-word bit positions and the sequencer state type.
package asap1_pkg;

  localparam int OPC_BITS  = 4;
  localparam int STEP_BITS = 3;

  localparam logic [OPC_BITS-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_BITS-1:0] OP_LDA = 4'h1;
  localparam logic [OPC_BITS-1:0] OP_ADD = 4'h2;
  localparam logic [OPC_BITS-1:0] OP_SUB = 4'h3;
  localparam logic [OPC_BITS-1:0] OP_STA = 4'h4;
  localparam logic [OPC_BITS-1:0] OP_LDI = 4'h5;
  localparam logic [OPC_BITS-1:0] OP_JMP = 4'h6;
  localparam logic [OPC_BITS-1:0] OP_JC  = 4'h7;
  localparam logic [OPC_BITS-1:0] OP_JZ  = 4'h8;
  localparam logic [OPC_BITS-1:0] OP_OUT = 4'hE;
  localparam logic [OPC_BITS-1:0] OP_HLT = 4'hF;

  localparam logic [STEP_BITS-1:0] T0 = 3'd0;
  localparam logic [STEP_BITS-1:0] T1 = 3'd1;
  localparam logic [STEP_BITS-1:0] T2 = 3'd2;
  localparam logic [STEP_BITS-1:0] T3 = 3'd3;
  localparam logic [STEP_BITS-1:0] T4 = 3'd4;

  localparam int CW_W   = 16;
  localparam int CW_HLT = 15;
  localparam int CW_CO  = 14;
  localparam int CW_CE  = 13;
  localparam int CW_J   = 12;
  localparam int CW_MI  = 11;
  localparam int CW_RI  = 10;
  localparam int CW_RO  = 9;
  localparam int CW_II  = 8;
  localparam int CW_IO  = 7;
  localparam int CW_AI  = 6;
  localparam int CW_AO  = 5;
  localparam int CW_BI  = 4;
  localparam int CW_EO  = 3;
  localparam int CW_SU  = 2;
  localparam int CW_OI  = 1;
  localparam int CW_FI  = 0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } seq_state_t;

endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// Combinational microcode: (opcode, step, fz, fc) -> control word, done, halt_req.
// SEQ_COND_JUMP_EN enables JC/JZ and the flags load in ADD/SUB T4; otherwise JC/JZ are NOPs.
module microcode_rom
  import asap1_pkg::*;
(
  input  logic [OPC_BITS-1:0]  opcode,
  input  logic [STEP_BITS-1:0] step,
  input  logic                 fz,
  input  logic                 fc,
  output logic [CW_W-1:0]      cw,
  output logic                 done,
  output logic                 halt_req
);

`ifndef SEQ_COND_JUMP_EN
  logic unused_rom_flags;
  assign unused_rom_flags = fz ^ fc;
`endif

  always_comb begin
    cw       = '0;
    done     = 1'b0;
    halt_req = 1'b0;
    case (step)
      T0: begin
        cw[CW_CO] = 1'b1;
        cw[CW_MI] = 1'b1;
      end
      T1: begin
        cw[CW_RO] = 1'b1;
        cw[CW_II] = 1'b1;
        cw[CW_CE] = 1'b1;
      end
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CW_IO] = 1'b1;
            cw[CW_MI] = 1'b1;
          end
          OP_LDI: begin
            cw[CW_IO] = 1'b1;
            cw[CW_AI] = 1'b1;
            done      = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IO] = 1'b1;
            cw[CW_J]  = 1'b1;
            done      = 1'b1;
          end
`ifdef SEQ_COND_JUMP_EN
          OP_JC: begin
            cw[CW_IO] = fc;
            cw[CW_J]  = fc;
            done      = 1'b1;
          end
          OP_JZ: begin
            cw[CW_IO] = fz;
            cw[CW_J]  = fz;
            done      = 1'b1;
          end
`else
          OP_JC, OP_JZ: done = 1'b1;
`endif
          OP_OUT: begin
            cw[CW_AO] = 1'b1;
            cw[CW_OI] = 1'b1;
            done      = 1'b1;
          end
          OP_HLT: begin
            cw[CW_HLT] = 1'b1;
            halt_req   = 1'b1;
          end
          OP_NOP:  done = 1'b1;
          default: done = 1'b1;
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: begin
            cw[CW_RO] = 1'b1;
            cw[CW_AI] = 1'b1;
            done      = 1'b1;
          end
          // su is raised a step early so the ALU sees it before B changes
          OP_ADD, OP_SUB: begin
            cw[CW_RO] = 1'b1;
            cw[CW_BI] = 1'b1;
            cw[CW_SU] = (opcode == OP_SUB);
          end
          OP_STA: begin
            cw[CW_AO] = 1'b1;
            cw[CW_RI] = 1'b1;
            done      = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
      T4: begin
        done = 1'b1;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw[CW_EO] = 1'b1;
          cw[CW_AI] = 1'b1;
          cw[CW_SU] = (opcode == OP_SUB);
`ifdef SEQ_COND_JUMP_EN
          cw[CW_FI] = 1'b1;
`endif
        end
      end
      default: done = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Step counter, HALTED state and flags register around the microcode ROM.
// SEQ_COND_JUMP_EN adds the fz/fc flags register used by JC/JZ.
//
// state     | meaning
// ST_RUN    | stepping T0..T4 through fetch and execute
// ST_HALTED | hlt held, step frozen at T2, exit only by reset
module control_sequencer
  import asap1_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zf,
  input  logic                cf,
  output logic                hlt,
  output logic                co,
  output logic                ce,
  output logic                j,
  output logic                mi,
  output logic                ri,
  output logic                ro,
  output logic                ii,
  output logic                io,
  output logic                ai,
  output logic                ao,
  output logic                bi,
  output logic                eo,
  output logic                su,
  output logic                oi,
  output logic                fi,
  output logic                fz,
  output logic                fc,
  output logic [STEP_W-1:0]   step
);

  seq_state_t        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CW_W-1:0]   rom_cw, cw;
  logic              rom_done, rom_halt;
  logic              flag_z, flag_c;

  microcode_rom u_rom (
    .opcode   (opcode),
    .step     (step_q),
    .fz       (flag_z),
    .fc       (flag_c),
    .cw       (rom_cw),
    .done     (rom_done),
    .halt_req (rom_halt)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cw      = '0;
    case (state_q)
      ST_RUN: begin
        cw = rom_cw;
        if (rom_halt)          state_d = ST_HALTED;
        else if (rom_done)     step_d  = T0;
        else if (step_q < T4)  step_d  = step_q + 1'b1;
        else                   step_d  = T0;
      end
      ST_HALTED: begin
        cw[CW_HLT] = 1'b1;
        step_d     = T2;
      end
      default: state_d = ST_RUN;
    endcase
    // strobes are gated by reset directly so an abort never leaves a partial word on the bus
    if (!rst) cw = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      step_q  <= T0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

`ifdef SEQ_COND_JUMP_EN
  logic fz_q, fz_d, fc_q, fc_d;

  always_comb begin
    fz_d = fz_q;
    fc_d = fc_q;
    if (cw[CW_FI]) begin
      fz_d = zf;
      fc_d = cf;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fz_q <= 1'b0;
      fc_q <= 1'b0;
    end else begin
      fz_q <= fz_d;
      fc_q <= fc_d;
    end
  end

  assign flag_z = fz_q;
  assign flag_c = fc_q;
`else
  logic unused_alu_flags;
  assign unused_alu_flags = zf ^ cf;
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
`endif

  assign hlt  = cw[CW_HLT];
  assign co   = cw[CW_CO];
  assign ce   = cw[CW_CE];
  assign j    = cw[CW_J];
  assign mi   = cw[CW_MI];
  assign ri   = cw[CW_RI];
  assign ro   = cw[CW_RO];
  assign ii   = cw[CW_II];
  assign io   = cw[CW_IO];
  assign ai   = cw[CW_AI];
  assign ao   = cw[CW_AO];
  assign bi   = cw[CW_BI];
  assign eo   = cw[CW_EO];
  assign su   = cw[CW_SU];
  assign oi   = cw[CW_OI];
  assign fi   = cw[CW_FI];
  assign fz   = flag_z;
  assign fc   = flag_c;
  assign step = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: instruction-level model builds the
// expected control words per instruction; random opcodes plus directed scenarios.
`timescale 1ns/1ps
module tb_control_sequencer;

  localparam logic [15:0] W_HLT = 16'h8000, W_CO = 16'h4000, W_CE = 16'h2000, W_J  = 16'h1000;
  localparam logic [15:0] W_MI  = 16'h0800, W_RI = 16'h0400, W_RO = 16'h0200, W_II = 16'h0100;
  localparam logic [15:0] W_IO  = 16'h0080, W_AI = 16'h0040, W_AO = 16'h0020, W_BI = 16'h0010;
  localparam logic [15:0] W_EO  = 16'h0008, W_SU = 16'h0004, W_OI = 16'h0002, W_FI = 16'h0001;
`ifdef SEQ_COND_JUMP_EN
  localparam logic [15:0] FI_W = W_FI;
`else
  localparam logic [15:0] FI_W = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic zf = 1'b0, cf = 1'b0;
  logic hlt, co, ce, j, mi, ri, ro, ii, io, ai, ao, bi, eo, su, oi, fi, fz, fc;
  logic [2:0] step;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zf(zf), .cf(cf),
    .hlt(hlt), .co(co), .ce(ce), .j(j), .mi(mi), .ri(ri), .ro(ro), .ii(ii), .io(io),
    .ai(ai), .ao(ao), .bi(bi), .eo(eo), .su(su), .oi(oi), .fi(fi), .fz(fz), .fc(fc),
    .step(step)
  );

  wire [15:0] dut_cw = {hlt, co, ce, j, mi, ri, ro, ii, io, ai, ao, bi, eo, su, oi, fi};

  int n_pass = 0, n_total = 0;

  logic [15:0] wq[$];
  int          idx = 0;
  int          op_q[$];
  int          cur_op = 0;
  bit          cur_fix = 0, cur_z = 0, cur_c = 0;
  bit          m_halted = 0, m_fz = 0, m_fc = 0;
  bit          prev_fi = 0, prev_z = 0, prev_c = 0;
  logic [15:0] exp_cw = '0;
  logic [2:0]  exp_step = '0;
  logic        exp_fz = 1'b0, exp_fc = 1'b0;
  bit          exp_valid = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, req);
  endtask

  function automatic int qop(input int op, input bit fix, input bit z, input bit c);
    return op | (int'(z) << 8) | (int'(c) << 9) | (int'(fix) << 10);
  endfunction

  // Whole-instruction list of expected control words, indexed by step.
  task automatic build(input int op);
    logic [15:0] s;
    wq.delete();
    wq.push_back(W_CO | W_MI);
    wq.push_back(W_RO | W_II | W_CE);
    s = (op == 3) ? W_SU : 16'h0;
    case (op)
      1: begin wq.push_back(W_IO | W_MI); wq.push_back(W_RO | W_AI); end
      2, 3: begin
        wq.push_back(W_IO | W_MI);
        wq.push_back(W_RO | W_BI | s);
        wq.push_back(W_EO | W_AI | FI_W | s);
      end
      4: begin wq.push_back(W_IO | W_MI); wq.push_back(W_AO | W_RI); end
      5: wq.push_back(W_IO | W_AI);
      6: wq.push_back(W_IO | W_J);
`ifdef SEQ_COND_JUMP_EN
      7: wq.push_back(m_fc ? (W_IO | W_J) : 16'h0);
      8: wq.push_back(m_fz ? (W_IO | W_J) : 16'h0);
`endif
      14: wq.push_back(W_AO | W_OI);
      15: wq.push_back(W_HLT);
      default: wq.push_back(16'h0);
    endcase
  endtask

  // Advance the model by one cycle; called just after each rising edge once inputs are set.
  task automatic tick();
    int e;
    if (!rst) begin
      m_fz = 0; m_fc = 0; m_halted = 0; prev_fi = 0;
      wq.delete(); idx = 0;
      exp_cw = '0; exp_step = '0;
    end else begin
      if (prev_fi) begin m_fz = prev_z; m_fc = prev_c; end
      if (m_halted) begin
        exp_cw = W_HLT; exp_step = 3'd2;
      end else begin
        if (idx >= wq.size()) begin
          if (op_q.size() > 0) begin
            e = op_q.pop_front();
            cur_op = e & 15; cur_z = e[8]; cur_c = e[9]; cur_fix = e[10];
          end else begin
            cur_op = int'($urandom_range(0, 14)); cur_fix = 0;
          end
          opcode = 4'(cur_op);
          build(cur_op);
          idx = 0;
        end
        exp_cw = wq[idx]; exp_step = 3'(idx); idx++;
        if (cur_op == 15 && idx == 3) m_halted = 1;
      end
      zf = cur_fix ? cur_z : 1'($urandom_range(0, 1));
      cf = cur_fix ? cur_c : 1'($urandom_range(0, 1));
      prev_fi = (exp_cw & W_FI) != 0;
      prev_z = zf; prev_c = cf;
    end
    exp_fz = m_fz; exp_fc = m_fc; exp_valid = 1;
  endtask

  task automatic cyc(input bit r);
    @(posedge clk); #2;
    rst = r;
    tick();
  endtask

  task automatic to_boundary();
    for (int k = 0; k < 6 && idx < wq.size(); k++) cyc(1'b1);
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("cw", 32'(dut_cw), 32'(exp_cw));
      chk("step", 32'(step), 32'(exp_step));
      chk("fz", 32'(fz), 32'(exp_fz));
      chk("fc", 32'(fc), 32'(exp_fc));
    end
  end

  initial begin
    #1 rst = 1'b0;
    repeat (3) cyc(1'b0);
    #1;
    chk("reset_cw", 32'(dut_cw), 32'h0);
    chk("reset_step", 32'(step), 32'h0);
    chk("reset_flags", 32'({fz, fc}), 32'h0);

    op_q.push_back(qop(0, 0, 0, 0));
    op_q.push_back(qop(2, 1, 0, 1));
    op_q.push_back(qop(3, 1, 0, 0));
    op_q.push_back(qop(7, 0, 0, 0));
    op_q.push_back(qop(2, 1, 0, 1));
    op_q.push_back(qop(7, 0, 0, 0));

    cyc(1'b1); #1 chk("nop_t0", 32'(dut_cw), 32'h4800);
    cyc(1'b1); #1 chk("nop_t1", 32'(dut_cw), 32'h2300);
    cyc(1'b1); #1 chk("nop_t2", 32'(dut_cw), 32'h0);
    cyc(1'b1); #1 chk("add_t0", 32'(dut_cw), 32'h4800);
    cyc(1'b1);
    cyc(1'b1); #1 chk("add_t2", 32'(dut_cw), 32'h0880);
    cyc(1'b1); #1 chk("add_t3", 32'(dut_cw), 32'h0210);
    cyc(1'b1); #1 chk("add_t4", 32'(dut_cw), 32'(16'h0048 | FI_W));
    cyc(1'b1); #1 chk("after_add_step", 32'(step), 32'h0);
`ifdef SEQ_COND_JUMP_EN
    chk("after_add_fc", 32'(fc), 32'h1);
    chk("after_add_fz", 32'(fz), 32'h0);
`endif
    cyc(1'b1); cyc(1'b1);
    cyc(1'b1); #1 chk("sub_t3", 32'(dut_cw), 32'h0214);
    cyc(1'b1); #1 chk("sub_t4", 32'(dut_cw), 32'(16'h004C | FI_W));
    cyc(1'b1); cyc(1'b1);
    cyc(1'b1); #1 chk("jc_nc_t2", 32'(dut_cw), 32'h0);
    repeat (5) cyc(1'b1);
    cyc(1'b1); cyc(1'b1);
`ifdef SEQ_COND_JUMP_EN
    cyc(1'b1); #1 chk("jc_c_t2", 32'(dut_cw), 32'h1080);
`else
    cyc(1'b1); #1 chk("jc_c_t2", 32'(dut_cw), 32'h0);
`endif

    repeat (400) cyc(1'b1);

    to_boundary();
    op_q.push_back(qop(2, 1, 0, 1));
    op_q.push_back(qop(1, 0, 0, 0));
    repeat (5) cyc(1'b1);
    repeat (4) cyc(1'b1);
    #1 chk("lda_t3_ro", 32'(ro), 32'h1);
`ifdef SEQ_COND_JUMP_EN
    chk("lda_pre_fc", 32'(fc), 32'h1);
`endif
    rst = 1'b0;
    tick();
    #1;
    chk("async_ro", 32'(ro), 32'h0);
    chk("async_ai", 32'(ai), 32'h0);
    chk("async_flags", 32'({fz, fc}), 32'h0);
    cyc(1'b0);
    cyc(1'b1); #1 chk("lda_restart", 32'(dut_cw), 32'h4800);

    repeat (50) cyc(1'b1);
    to_boundary();
    op_q.push_back(qop(15, 0, 0, 0));
    repeat (3) cyc(1'b1);
    repeat (22) cyc(1'b1);
    #1;
    chk("halt_cw", 32'(dut_cw), 32'h8000);
    chk("halt_step", 32'(step), 32'h2);
    cyc(1'b0);
    cyc(1'b1); #1;
    chk("halt_exit_cw", 32'(dut_cw), 32'h4800);
    chk("halt_exit_step", 32'(step), 32'h0);
    repeat (40) cyc(1'b1);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
